// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD helpers for countdown_timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_down.sv
// bcd_digit_down: one BCD down-counter digit with clamped load, enable and borrow out
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic [3:0] o_digit,
  output logic       o_borrow,
  output logic       o_is_zero
);

  logic [3:0] r_digit;

  assign o_digit   = r_digit;
  assign o_is_zero = (r_digit == 4'd0);
  assign o_borrow  = i_en && o_is_zero;

  // load wins over decrement; decrementing from 0 wraps to 9 and borrows
  always_ff @(posedge clock) begin
    if (!reset_n)
      r_digit <= 4'd0;
    else if (i_load)
      r_digit <= bcd_clamp(i_load_val);
    else if (i_en)
      r_digit <= o_is_zero ? BCD_MAX : r_digit - 4'd1;
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD seconds countdown driven by a tick stream
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_load_bcd,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [7:0] o_secs_bcd,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_expire_pulse
);

  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);

  state_t        r_state;
  logic [SW-1:0] r_sub;
  logic [3:0]    w_ones, w_tens;
  logic          w_ones_zero, w_tens_zero, w_ones_borrow, w_tens_borrow;
  logic          w_count, w_wrap, w_dec, w_last;

  // a tick counts only while running with no higher-priority command present
  assign w_count = (r_state == ST_RUNNING) && i_tick && !i_load && !i_pause;
  assign w_wrap  = w_count && (r_sub == SUB_LAST);
  assign w_dec   = w_wrap && !(w_ones_zero && w_tens_zero);
  assign w_last  = w_dec && w_tens_zero && (w_ones == 4'd1);

  assign o_secs_bcd = {w_tens, w_ones};

  bcd_digit_down u_ones (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (i_load),
    .i_load_val(i_load_bcd[3:0]),
    .i_en      (w_dec),
    .o_digit   (w_ones),
    .o_borrow  (w_ones_borrow),
    .o_is_zero (w_ones_zero)
  );

  bcd_digit_down u_tens (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (i_load),
    .i_load_val(i_load_bcd[7:4]),
    .i_en      (w_ones_borrow),
    .o_digit   (w_tens),
    .o_borrow  (w_tens_borrow),
    .o_is_zero (w_tens_zero)
  );

  // control FSM with sub-tick counter and registered status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_sub          <= '0;
      o_running      <= 1'b0;
      o_expired      <= 1'b0;
      o_expire_pulse <= 1'b0;
    end else begin
      o_expire_pulse <= 1'b0;
      if (i_load) begin
        r_state   <= ST_IDLE;
        r_sub     <= '0;
        o_running <= 1'b0;
        o_expired <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE:
            if (i_start && !i_pause) begin
              if (w_ones_zero && w_tens_zero) begin
                r_state        <= ST_EXPIRED;
                o_expired      <= 1'b1;
                o_expire_pulse <= 1'b1;
              end else begin
                r_state   <= ST_RUNNING;
                o_running <= 1'b1;
              end
            end
          ST_RUNNING:
            if (i_pause) begin
              r_state   <= ST_PAUSED;
              o_running <= 1'b0;
            end else if (w_count) begin
              r_sub <= w_wrap ? '0 : r_sub + 1'b1;
              if (w_last || w_tens_borrow) begin
                r_state        <= ST_EXPIRED;
                o_running      <= 1'b0;
                o_expired      <= 1'b1;
                o_expire_pulse <= 1'b1;
              end
            end
          ST_PAUSED:
            if (i_start && !i_pause) begin
              r_state   <= ST_RUNNING;
              o_running <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer at 4 and 60 ticks per second
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_bcd = 8'h00;
  logic [7:0] secs4, secs60;
  logic       run4, exp4, pls4, run60, exp60, pls60;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         due;
    bit         sel;
    logic [10:0] exp;
  } item_t;

  item_t q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  countdown_timer #(.TICKS_PER_SEC(4)) u4 (
    .clock(clock), .reset_n(reset_n), .i_tick(tick), .i_load(load), .i_load_bcd(load_bcd),
    .i_start(start), .i_pause(pause), .o_secs_bcd(secs4), .o_running(run4),
    .o_expired(exp4), .o_expire_pulse(pls4)
  );

  countdown_timer #(.TICKS_PER_SEC(60)) u60 (
    .clock(clock), .reset_n(reset_n), .i_tick(tick), .i_load(load), .i_load_bcd(load_bcd),
    .i_start(start), .i_pause(pause), .o_secs_bcd(secs60), .o_running(run60),
    .o_expired(exp60), .o_expire_pulse(pls60)
  );

  // monitor: compare every expectation that falls due in this cycle
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      logic [10:0] act;
      it = q.pop_front();
      act = it.sel ? {secs60, run60, exp60, pls60} : {secs4, run4, exp4, pls4};
      checks++;
      if (it.due != cyc || act !== it.exp) begin
        errors++;
        $display("FAIL %s: got secs=%h run=%b exp=%b pulse=%b, want secs=%h run=%b exp=%b pulse=%b",
                 it.name, act[10:3], act[2], act[1], act[0],
                 it.exp[10:3], it.exp[2], it.exp[1], it.exp[0]);
      end
    end
  end

  task automatic drive(input logic r, input logic l, input logic [7:0] v,
                       input logic s, input logic p, input logic t);
    @(posedge clock);
    #1;
    reset_n = r; load = l; load_bcd = v; start = s; pause = p; tick = t;
  endtask

  task automatic expect_out(input string n, input bit sel, input logic [7:0] s,
                            input logic r, input logic e, input logic p);
    item_t it;
    it.name = n; it.due = cyc + 1; it.sel = sel; it.exp = {s, r, e, p};
    q.push_back(it);
  endtask

  task automatic idle();
    drive(1, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 8'h00, 0, 0, 1);
  endtask

  initial begin
    drive(0, 0, 8'h00, 0, 0, 0);
    expect_out("reset", 0, 8'h00, 0, 0, 0);
    idle();
    drive(1, 1, 8'h12, 0, 0, 0); expect_out("load12", 0, 8'h12, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0); expect_out("start12", 0, 8'h12, 1, 0, 0);
    ticks(3); expect_out("12_3ticks", 0, 8'h12, 1, 0, 0);
    ticks(1); expect_out("12to11", 0, 8'h11, 1, 0, 0);
    ticks(4); expect_out("11to10", 0, 8'h10, 1, 0, 0);
    ticks(4); expect_out("10to09", 0, 8'h09, 1, 0, 0);
    drive(1, 1, 8'h02, 0, 0, 0); expect_out("load02", 0, 8'h02, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(4); expect_out("02to01", 0, 8'h01, 1, 0, 0);
    ticks(4); expect_out("expire", 0, 8'h00, 0, 1, 1);
    idle(); expect_out("pulse_drop", 0, 8'h00, 0, 1, 0);
    ticks(5); expect_out("exp_ticks", 0, 8'h00, 0, 1, 0);
    drive(1, 0, 8'h00, 1, 0, 0); expect_out("exp_start", 0, 8'h00, 0, 1, 0);
    drive(1, 1, 8'h05, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(2);
    drive(1, 0, 8'h00, 0, 1, 0); expect_out("pause", 0, 8'h05, 0, 0, 0);
    ticks(10); expect_out("paused_ticks", 0, 8'h05, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0); expect_out("resume", 0, 8'h05, 1, 0, 0);
    ticks(1); expect_out("resume_t1", 0, 8'h05, 1, 0, 0);
    ticks(1); expect_out("resume_t2", 0, 8'h04, 1, 0, 0);
    drive(1, 1, 8'hAF, 0, 0, 0); expect_out("clamp", 0, 8'h99, 0, 0, 0);
    drive(1, 1, 8'h00, 0, 0, 0); expect_out("load00", 0, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0); expect_out("start00", 0, 8'h00, 0, 1, 1);
    idle(); expect_out("start00_drop", 0, 8'h00, 0, 1, 0);
    drive(1, 1, 8'h30, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(3);
    drive(1, 1, 8'h45, 0, 1, 1); expect_out("load_over_tick", 0, 8'h45, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(3); expect_out("sub_cleared", 0, 8'h45, 1, 0, 0);
    ticks(1); expect_out("45to44", 0, 8'h44, 1, 0, 0);
    drive(1, 1, 8'h07, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(2);
    drive(0, 0, 8'h00, 0, 0, 1); expect_out("mid_reset", 0, 8'h00, 0, 0, 0);
    drive(1, 1, 8'h01, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(3); expect_out("01_3ticks", 0, 8'h01, 1, 0, 0);
    ticks(1); expect_out("01_expire", 0, 8'h00, 0, 1, 1);
    drive(1, 1, 8'h01, 0, 0, 0); expect_out("t60_load", 1, 8'h01, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    ticks(59); expect_out("t60_59", 1, 8'h01, 1, 0, 0);
    ticks(1); expect_out("t60_expire", 1, 8'h00, 0, 1, 1);
    idle(); expect_out("t60_drop", 1, 8'h00, 0, 1, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
